// File: rtl/nd_array_pkg.sv
// Shared definitions for the nd-array packing / slice / permute path.
// Default frame geometry is [5:0][3:0][2:0]; modules take these values as
// parameter defaults so the geometry can still be overridden per instance.
package nd_array_pkg;

  localparam int ROWS      = 6;
  localparam int COLS      = 4;
  localparam int ELEM_W    = 3;
  localparam int ROW_CNT_W = $clog2(ROWS + 1);

  typedef logic [ELEM_W-1:0] elem_t;
  typedef elem_t [COLS-1:0]  row_t;
  typedef row_t  [ROWS-1:0]  frame_t;

  // Single-bank packer states: collecting rows, or presenting a closed frame.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } fill_state_t;

endpackage

// File: rtl/nd_frame_bank.sv
// One frame bank: row storage, per-row written mask, row count of the
// closed frame and a full flag. Rows that were never written in the
// current frame read as zero through the mask, so storage is never cleared.
module nd_frame_bank #(
  parameter int ROWS   = nd_array_pkg::ROWS,
  parameter int COLS   = nd_array_pkg::COLS,
  parameter int ELEM_W = nd_array_pkg::ELEM_W,
  parameter int CNT_W  = $clog2(ROWS + 1)
) (
  input  logic                                 clk,
  input  logic                                 srst,
  input  logic                                 wr_en,
  input  logic                                 wr_last,
  input  logic [COLS-1:0][ELEM_W-1:0]          wr_row,
  input  logic                                 clr,
  output logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0] frame,
  output logic [CNT_W-1:0]                     rows,
  output logic                                 full,
  output logic                                 close,
  output logic                                 len_err
);

  logic [COLS-1:0][ELEM_W-1:0] store_q [ROWS];
  logic [COLS-1:0][ELEM_W-1:0] store_d [ROWS];
  logic [ROWS-1:0]             mask_q, mask_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            rows_q, rows_d;
  logic                        full_q, full_d;
  logic                        last_row;

  // Next-state for the write pointer, mask, frame length and full flag.
  always_comb begin
    last_row = (cnt_q == CNT_W'(ROWS - 1));
    // A write closes the frame on in_last or when the last row slot fills.
    close    = wr_en && (wr_last || last_row);
    // Length mismatch: last flagged early, or missing on the final row.
    len_err  = wr_en && (wr_last != last_row);
    store_d  = store_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    rows_d   = rows_q;
    full_d   = full_q;
    if (clr) begin
      mask_d = '0;
      cnt_d  = '0;
      rows_d = '0;
      full_d = 1'b0;
    end else if (wr_en) begin
      for (int r = 0; r < ROWS; r++) begin
        if (cnt_q == CNT_W'(r)) begin
          store_d[r] = wr_row;
          mask_d[r]  = 1'b1;
        end
      end
      if (close) begin
        full_d = 1'b1;
        rows_d = cnt_q + 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Control state registers; storage contents are left alone on reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      mask_q <= '0;
      cnt_q  <= '0;
      rows_q <= '0;
      full_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      rows_q <= rows_d;
      full_q <= full_d;
    end
  end

  // Row storage register array; every row must be visible at once downstream.
  always_ff @(posedge clk) begin
    store_q <= store_d;
  end

  // Unwritten rows of the current frame read as zero.
  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_mask
      assign frame[gi] = mask_q[gi] ? store_q[gi] : '0;
    end
  endgenerate

  assign rows = rows_q;
  assign full = full_q;

endmodule

// File: rtl/nd_row_packer.sv
// Row packer: assembles rows from a valid/ready stream into a full frame and
// holds it stable for the downstream slice/permute stage.
// Build option: define ND_PACKER_DOUBLE_BUF_EN for two ping-pong banks
// (one row per cycle sustained); otherwise a single bank with a FILL/HOLD
// state machine is built. Ports are identical in both builds.
module nd_row_packer
  import nd_array_pkg::*;
#(
  parameter int ROWS   = nd_array_pkg::ROWS,
  parameter int COLS   = nd_array_pkg::COLS,
  parameter int ELEM_W = nd_array_pkg::ELEM_W
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic [COLS-1:0][ELEM_W-1:0]          in_row,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0] out_frame,
  output logic [$clog2(ROWS+1)-1:0]            out_rows,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 err_len
);

`ifdef ND_PACKER_DOUBLE_BUF_EN
  localparam int NBANKS = 2;
`else
  localparam int NBANKS = 1;
`endif
  localparam int CNT_W = $clog2(ROWS + 1);

  logic                                 accept;
  logic                                 xfer;
  logic                                 wr_sel;
  logic                                 rd_sel;
  logic [NBANKS-1:0]                    bank_wr_en;
  logic [NBANKS-1:0]                    bank_clr;
  logic [NBANKS-1:0]                    bank_full;
  logic [NBANKS-1:0]                    bank_close;
  logic [NBANKS-1:0]                    bank_err;
  logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0] bank_frame [NBANKS];
  logic [CNT_W-1:0]                     bank_rows  [NBANKS];
  logic                                 err_len_q, err_len_d;

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  generate
    for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
      // A full bank is never written, so a held frame cannot be corrupted.
      assign bank_wr_en[gi] = accept && (int'(wr_sel) == gi) && !bank_full[gi];
      assign bank_clr[gi]   = xfer && (int'(rd_sel) == gi);

      nd_frame_bank #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ELEM_W (ELEM_W),
        .CNT_W  (CNT_W)
      ) u_bank (
        .clk     (CLK),
        .srst    (RESET),
        .wr_en   (bank_wr_en[gi]),
        .wr_last (in_last),
        .wr_row  (in_row),
        .clr     (bank_clr[gi]),
        .frame   (bank_frame[gi]),
        .rows    (bank_rows[gi]),
        .full    (bank_full[gi]),
        .close   (bank_close[gi]),
        .len_err (bank_err[gi])
      );
    end
  endgenerate

  // Length-error flag is sticky until reset.
  always_comb begin
    err_len_d = err_len_q | (|bank_err);
  end

  // Sticky length-error register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_len_q <= 1'b0;
    end else begin
      err_len_q <= err_len_d;
    end
  end

  assign err_len = err_len_q;

`ifdef ND_PACKER_DOUBLE_BUF_EN
  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;

  // Write pointer advances on a closing accept, read pointer on a transfer;
  // both walk the banks in the same order, so frames leave in fill order.
  always_comb begin
    wr_bank_d = wr_bank_q ^ (|bank_close);
    rd_bank_d = rd_bank_q ^ xfer;
  end

  // Bank pointer registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  assign wr_sel    = wr_bank_q;
  assign rd_sel    = rd_bank_q;
  assign in_ready  = !bank_full[wr_bank_q];
  assign out_valid = bank_full[rd_bank_q];
  assign out_frame = bank_frame[rd_bank_q];
  assign out_rows  = bank_rows[rd_bank_q];
`else
  fill_state_t state_q, state_d;
  logic        in_ready_q;
  logic        out_valid_q;

  // FILL closes into HOLD on the last accepted row; HOLD returns on transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (bank_close[0]) state_d = ST_HOLD;
      ST_HOLD: if (xfer)          state_d = ST_FILL;
      default:                    state_d = ST_FILL;
    endcase
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_FILL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_FILL);
      out_valid_q <= (state_d == ST_HOLD);
    end
  end

  assign wr_sel    = 1'b0;
  assign rd_sel    = 1'b0;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_frame = bank_frame[0];
  assign out_rows  = bank_rows[0];
`endif

endmodule

// File: tb/tb_nd_row_packer.sv
// Self-checking bench for nd_row_packer: a frame-level reference model fills
// an expected-frame queue as rows are issued; a monitor pops and compares on
// every output transfer. Honors ND_PACKER_DOUBLE_BUF_EN for build-specific
// backpressure and streaming expectations.
module tb_nd_row_packer;

  localparam int ROWS   = 6;
  localparam int COLS   = 4;
  localparam int ELEM_W = 3;
  localparam int RW     = COLS * ELEM_W;
  localparam int FW     = ROWS * RW;
  localparam int CNT_W  = $clog2(ROWS + 1);

  typedef struct {
    logic [FW-1:0] frame;
    int            rows;
  } exp_t;

  logic             CLK;
  logic             RESET;
  logic [RW-1:0]    in_row;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [FW-1:0]    out_frame;
  logic [CNT_W-1:0] out_rows;
  logic             out_valid;
  logic             out_ready;
  logic             err_len;

  int total = 0;
  int bad   = 0;

  exp_t          exp_q[$];
  logic [RW-1:0] cur_rows[$];
  logic          err_model = 1'b0;
  int            ready_mode = 0;  // 0 low, 1 high, 2 random
  bit            stream_chk = 1'b0;

  nd_row_packer #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ELEM_W (ELEM_W)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_row    (in_row),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_frame (out_frame),
    .out_rows  (out_rows),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_len   (err_len)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // out_ready changes just after the rising edge, so negedge sampling is clean.
  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: a frame ends on last or when ROWS rows are collected.
  task automatic model_accept(input logic [RW-1:0] r, input bit last);
    exp_t e;
    cur_rows.push_back(r);
    if (last || cur_rows.size() == ROWS) begin
      e.frame = '0;
      for (int k = 0; k < cur_rows.size(); k++) e.frame[k*RW +: RW] = cur_rows[k];
      e.rows = cur_rows.size();
      if (cur_rows.size() != ROWS || !last) err_model = 1'b1;
      exp_q.push_back(e);
      cur_rows.delete();
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_row(input logic [RW-1:0] r, input bit last);
    int n = 0;
    in_row   = r;
    in_last  = last;
    in_valid = 1'b1;
    if (stream_chk) chk("stream_in_ready", in_ready, 1);
    while (!in_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles want accept", n);
    end else begin
      model_accept(r, last);
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit last_on_end);
    for (int k = 0; k < len; k++)
      send_row(RW'($urandom), (k == len - 1) ? last_on_end : 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d frames pending want 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1 RESET = 1'b1;
    cur_rows.delete();
    exp_q.delete();
    err_model = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
  endtask

  // Monitor: compare each transferred frame; held frames must not change.
  logic [FW-1:0]    prev_frame;
  logic [CNT_W-1:0] prev_rows;
  bit               have_prev = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      have_prev = 1'b0;
    end else begin
      if (out_valid && have_prev) begin
        chk("hold_frame_stable", out_frame, prev_frame);
        chk("hold_rows_stable", out_rows, prev_rows);
      end
      if (out_valid && out_ready) begin
        have_prev = 1'b0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got frame %0h want none", out_frame);
        end else begin
          e = exp_q.pop_front();
          chk("frame_data", out_frame, e.frame);
          chk("frame_rows", out_rows, e.rows);
        end
      end else if (out_valid) begin
        prev_frame = out_frame;
        prev_rows  = out_rows;
        have_prev  = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    RESET     = 1'b1;
    in_row    = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_rows", out_rows, 0);
    chk("reset_out_frame", out_frame, 0);
    chk("reset_err_len", err_len, 0);

    // Clean 6-row frame, rows 0x000..0x555.
    ready_mode = 1;
    repeat (2) @(negedge CLK);
    for (int k = 0; k < ROWS; k++) send_row(RW'(k * 12'h111), k == ROWS - 1);
    chk("t1_valid_latency1", out_valid, 1);
    chk("t1_err_len", err_len, 0);
    @(negedge CLK);
    chk("t1_valid_one_cycle", out_valid, 0);
    drain();

    // Backpressure for 10 cycles after the frame completes.
    ready_mode = 0;
    repeat (2) @(negedge CLK);
    send_frame(ROWS, 1'b1);
`ifdef ND_PACKER_DOUBLE_BUF_EN
    send_frame(ROWS, 1'b1);
    for (int c = 0; c < 10; c++) begin
      chk("bp_in_ready_low", in_ready, 0);
      @(negedge CLK);
    end
`else
    for (int c = 0; c < 10; c++) begin
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid_high", out_valid, 1);
      @(negedge CLK);
    end
`endif
    ready_mode = 1;
    drain();

    // Early last on the third row.
    send_row(12'hABC, 1'b0);
    send_row(12'hDEF, 1'b0);
    send_row(12'h123, 1'b1);
    drain();
    chk("early_err_len", err_len, 1);
    send_frame(ROWS, 1'b1);
    drain();
    chk("err_len_sticky", err_len, 1);

    // Missing last.
    do_reset();
    chk("reset_clears_err", err_len, 0);
    send_frame(ROWS, 1'b0);
    drain();
    chk("missing_last_err", err_len, 1);

    // Reset in the middle of a frame.
    do_reset();
    send_frame(4, 1'b0);
    do_reset();
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_err_len", err_len, 0);
    chk("midreset_in_ready", in_ready, 1);
    send_frame(ROWS, 1'b1);
    drain();
    chk("midreset_clean_err", err_len, 0);

    // Four frames back to back.
`ifdef ND_PACKER_DOUBLE_BUF_EN
    stream_chk = 1'b1;
`endif
    for (int f = 0; f < 4; f++) send_frame(ROWS, 1'b1);
    stream_chk = 1'b0;
    drain();

    // Randomized frames with random lengths, gaps and backpressure.
    ready_mode = 2;
    for (int f = 0; f < 20; f++) begin
      int len;
      bit lst;
      len = $urandom_range(1, ROWS);
      lst = (len < ROWS) ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) @(negedge CLK);
        send_row(RW'($urandom), (k == len - 1) ? lst : 1'b0);
      end
    end
    ready_mode = 1;
    drain();
    chk("rand_err_len", err_len, err_model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nd_row_packer.md
# nd_row_packer

Upstream packing stage for the nd-array index/permute logic: accepts a stream of rows, each `[COLS-1:0][ELEM_W-1:0]`, over a valid/ready handshake. It assembles them into a full `[ROWS-1:0][COLS-1:0][ELEM_W-1:0]` frame and presents that frame, held stable, to the combinational slice/permute stage downstream. Defaults produce the `[5:0][3:0][2:0]` frame that stage consumes.

## Interface
- `ROWS`, default 6: rows per frame; minimum 2.
- `COLS`, default 4: elements per row.
- `ELEM_W`, default 3: element width in bits.
- `CLK` input, 1: clock; all state updates on the rising edge.
- `RESET` input, 1: reset, synchronous and active-high.
- `in_row` input, `[COLS-1:0][ELEM_W-1:0]`: incoming row.
- `in_valid` input, 1: `in_row` and `in_last` are valid.
- `in_last` input, 1: final row of the frame; sampled only on accept.
- `in_ready` output, 1: packer can accept a row this cycle.
- `out_frame` output, `[ROWS-1:0][COLS-1:0][ELEM_W-1:0]`: assembled frame; row k is the k-th accepted row.
- `out_rows` output, `$clog2(ROWS+1)`: number of rows actually written into `out_frame`.
- `out_valid` output, 1: frame is complete.
- `out_ready` input, 1: downstream takes the frame.
- `err_len` output, 1: sticky flag for a frame-length mismatch.

## Operation
- Accept: `in_valid && in_ready`. Transfer: `out_valid && out_ready`.
- Rows fill from index 0 upward; the write row counter runs 0..ROWS-1.
- A frame closes on the accept with `in_last=1`, or on the accept of row ROWS-1, whichever comes first.
- Early `in_last` at row r < ROWS-1:
  - frame closes with `out_rows = r+1`;
  - rows above r read as zero, via a per-row written mask, not by clearing storage;
  - `err_len` is set.
- Row ROWS-1 accepted with `in_last=0`:
  - frame closes with `out_rows = ROWS`;
  - `err_len` is set.
- `err_len` stays set until `RESET`.
- Single-buffer state machine:
  - FILL: `in_ready=1`, `out_valid=0`. A closing accept moves to HOLD.
  - HOLD: `in_ready=0`, `out_valid=1`. A transfer moves to FILL, with row counter 0 and mask cleared.
- `out_frame` and `out_rows` stay stable while `out_valid=1` and no transfer has occurred.
- `in_ready` is a function of state only; no combinational path from `out_ready` to `in_ready`.
- Reset values: `out_valid=0`, `in_ready=1` (one cycle after `RESET` falls is also acceptable only if documented; default is 1 in the reset cycle's following state), `out_rows=0`, `out_frame` all zero (mask cleared), `err_len=0`, row counter 0, state FILL.
- A `RESET` mid-frame discards partial rows and any held frame; no transfer is reported for them.

## Timing
- `out_valid` rises on the cycle after the closing accept, a latency of 1.
- Single-buffer throughput: ROWS+1 cycles per frame minimum. The cycle after a transfer, `in_ready` is 1.
- Double-buffer throughput: 1 row per cycle sustained while `out_ready=1`.
- A transfer and an accept in the same cycle are legal in double-buffer mode. They target different banks; the transfer and the accept both take effect.

## Configuration
- `ND_PACKER_DOUBLE_BUF_EN` defined: two frame banks, each with its own mask, `out_rows`, and full flag.
  - Write bank and read bank pointers toggle independently.
  - `in_ready = !full[wr_bank]`.
  - `out_valid = full[rd_bank]`.
  - Banks are presented strictly in fill order.
- Not defined: the single bank FILL/HOLD machine above. Ports are identical in both builds.

## Structure
- Shared package `nd_array_pkg`:
  - `ROWS`/`COLS`/`ELEM_W` defaults;
  - typedefs `elem_t`, `row_t` (`[COLS-1:0] elem_t`), `frame_t` (`[ROWS-1:0] row_t`);
  - `ROW_CNT_W = $clog2(ROWS+1)`.
- One sub-module, `nd_frame_bank`:
  - row storage, written mask, `out_rows`, full flag;
  - write-row and clear inputs;
  - masked frame output.
- One bank is instantiated in the single-buffer build, two in the double-buffer build.

## Test plan
- Six rows with values 0x000, 0x111, … 0x555, `in_last` on row 5, `out_ready=1`:
  - `out_frame[k]` = row k;
  - `out_rows=6`;
  - `out_valid` for 1 cycle;
  - `err_len=0`.
- Backpressure: hold `out_ready=0` for 10 cycles after the frame completes.
  - Single build: `out_frame` is stable and `in_ready=0` throughout.
  - Double build: a second 6-row frame is accepted, then `in_ready=0`.
  - Frames emerge in order.
- Early last: 3 rows 0xABC, 0xDEF, 0x123 with `in_last` on the third.
  - `out_rows=3`; rows 3..5 read as zero; `err_len=1`.
  - `err_len` stays 1 through the next clean frame.
- Missing last: 6 rows with `in_last=0` throughout → frame emitted with `out_rows=6` and `err_len=1`.
- Reset mid-frame: 4 rows accepted, then `RESET` for 1 cycle → `out_valid=0` and `err_len=0`. The next 6-row frame is emitted intact, with no rows from before the reset.
- Double build streaming: 4 frames back to back with `in_valid=1` and `out_ready=1` → `in_ready` is never deasserted after reset, and all 24 rows arrive in order.
